// File: rtl/decode_stage_pkg.sv
// decode_pkg: shared constants and types for the byte-serial x86-subset decoder.
// Holds opcode values, ModRM special values, the FSM state enum, the AG1 field
// encodings (op, immSize, disp_size) and small decode helper functions.
package decode_pkg;

    localparam logic [7:0] OPC_ADD_RM_R  = 8'h01;
    localparam logic [7:0] OPC_ADD_R_RM  = 8'h03;
    localparam logic [7:0] OPC_ADD_IMM32 = 8'h81;
    localparam logic [7:0] OPC_ADD_IMM8  = 8'h83;
    localparam logic [7:0] OPC_JMP_REL8  = 8'hEB;
    localparam logic [7:0] OPC_JMP_REL32 = 8'hE9;
    localparam logic [7:0] OPC_JMP_FAR   = 8'hEA;
    localparam logic [7:0] OPC_NOP       = 8'h90;

    localparam logic [1:0] MOD_IND = 2'b00;
    localparam logic [1:0] MOD_D8  = 2'b01;
    localparam logic [1:0] MOD_D32 = 2'b10;
    localparam logic [1:0] MOD_REG = 2'b11;
    localparam logic [2:0] RM_SIB  = 3'b100;
    localparam logic [2:0] RM_ABS  = 3'b101;

    typedef enum logic [2:0] {ST_OPC, ST_MODRM, ST_DISP, ST_IMM, ST_ILL} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_JMP_NEAR, OP_JMP_FAR, OP_RSVD} op_t;
    typedef enum logic [1:0] {IMM_NONE, IMM_8, IMM_32, IMM_48} imm_size_t;
    typedef enum logic [1:0] {DISP_NONE, DISP_8, DISP_32} disp_size_t;

    function automatic logic has_modrm(input logic [7:0] opc);
        return (opc == OPC_ADD_RM_R) || (opc == OPC_ADD_R_RM) ||
               (opc == OPC_ADD_IMM32) || (opc == OPC_ADD_IMM8);
    endfunction

    function automatic imm_size_t imm_size_of(input logic [7:0] opc);
        case (opc)
            OPC_ADD_IMM32, OPC_JMP_REL32: return IMM_32;
            OPC_ADD_IMM8,  OPC_JMP_REL8:  return IMM_8;
            OPC_JMP_FAR:                  return IMM_48;
            default:                      return IMM_NONE;
        endcase
    endfunction

    function automatic op_t op_of(input logic [7:0] opc);
        case (opc)
            OPC_JMP_REL8, OPC_JMP_REL32: return OP_JMP_NEAR;
            OPC_JMP_FAR:                 return OP_JMP_FAR;
            default:                     return OP_ADD;
        endcase
    endfunction

    function automatic disp_size_t disp_size_of(input logic [1:0] md, input logic [2:0] rm);
        if (md == MOD_D8)                      return DISP_8;
        if (md == MOD_D32)                     return DISP_32;
        if ((md == MOD_IND) && (rm == RM_ABS)) return DISP_32;
        return DISP_NONE;
    endfunction

    function automatic logic [2:0] imm_bytes(input imm_size_t s);
        case (s)
            IMM_8:   return 3'd1;
            IMM_32:  return 3'd4;
            IMM_48:  return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] disp_bytes(input disp_size_t s);
        case (s)
            DISP_8:  return 3'd1;
            DISP_32: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_field_asm.sv
// field_asm: little-endian byte assembler shared by the displacement and
// immediate phases of decode_stage.
//   clk, rst    clock, asynchronous active-low reset
//   clr         drop the partial field and restart at byte 0 (wins over load)
//   load        write byte_in at the current byte position
//   byte_in     incoming field byte
//   val         assembled field, including the byte being loaded this cycle
//   sext8       byte 0 of val sign-extended to 32 bits
//   cnt         number of bytes already stored
module field_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [47:0] val,
    output logic [31:0] sext8,
    output logic [2:0]  cnt
);
    logic [47:0] data_q;
    logic [2:0]  cnt_q;

    // val already contains the in-flight byte so the caller can capture a
    // complete field on the same edge that delivers its last byte.
    always_comb begin
        val = data_q;
        for (int unsigned i = 0; i < 6; i++) begin
            if (load && (cnt_q == 3'(i))) val[i*8 +: 8] = byte_in;
        end
    end

    assign sext8 = {{24{val[7]}}, val[7:0]};
    assign cnt   = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (clr) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            data_q <= val;
            cnt_q  <= cnt_q + 3'd1;
        end
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: byte-serial x86-subset decoder feeding AG1.
// Accepts one instruction byte per cycle (i_byte/i_byte_vld/o_byte_rdy),
// parses opcode, ModRM, displacement and immediate, and presents one decoded
// instruction in a single-entry output register (o_vld, held under i_stall).
// i_flush discards all partial and pending state. o_illegal is sticky until
// flush or reset. rst is asynchronous, active-low.
module decode_stage
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_vld,
    output logic        o_byte_rdy,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic        o_vld,
    output logic [2:0]  o_sr1,
    output logic [2:0]  o_sr2,
    output logic        o_isAddrbd,
    output logic        o_isO1Mem,
    output logic        o_isO2Mem,
    output logic        o_far_jmp,
    output logic [1:0]  o_immSize,
    output logic [47:0] o_imm,
    output logic [31:0] o_disp,
    output logic [1:0]  o_disp_size,
    output logic [1:0]  o_op,
    output logic [3:0]  o_len,
    output logic        o_illegal
);
    state_t     state, state_nxt;
    logic       take, complete, disp_latch, asm_load, asm_clr, phase_last, modrm_ok, is_add;
    logic [7:0] opc_q, modrm_q, opc_cur, modrm_cur;
    logic [1:0] mod_f;
    logic [2:0] reg_f, rm_f, asm_cnt;
    logic [3:0] len_q;
    logic [31:0] disp_q, disp_new, asm_sext8;
    logic [47:0] asm_val;
    imm_size_t  imm_sz_cur;
    disp_size_t disp_sz_q, disp_sz_cur;

    logic [2:0]  d_sr1, d_sr2;
    logic        d_addrbd, d_o1m, d_o2m;
    logic [47:0] d_imm;
    logic [31:0] d_disp;
    disp_size_t  d_dsz;

    assign o_byte_rdy = !i_flush && (state != ST_ILL) && !(o_vld && i_stall);
    assign take       = i_byte_vld && o_byte_rdy;
    assign o_illegal  = (state == ST_ILL);

    // Opcode/ModRM come straight from i_byte in the cycle they arrive so that
    // short instructions can complete on that same byte.
    assign opc_cur     = (state == ST_OPC)   ? i_byte : opc_q;
    assign modrm_cur   = (state == ST_MODRM) ? i_byte : modrm_q;
    assign mod_f       = modrm_cur[7:6];
    assign reg_f       = modrm_cur[5:3];
    assign rm_f        = modrm_cur[2:0];
    assign is_add      = has_modrm(opc_cur);
    assign imm_sz_cur  = imm_size_of(opc_cur);
    assign disp_sz_cur = (state == ST_MODRM) ? disp_size_of(mod_f, rm_f) : disp_sz_q;
    assign modrm_ok    = !(((opc_cur == OPC_ADD_IMM32) || (opc_cur == OPC_ADD_IMM8)) && (reg_f != 3'd0))
                      && !((mod_f != MOD_REG) && (rm_f == RM_SIB));
    assign phase_last  = (asm_cnt + 3'd1) ==
                         ((state == ST_DISP) ? disp_bytes(disp_sz_q) : imm_bytes(imm_sz_cur));
    assign disp_new    = (disp_sz_q == DISP_8) ? asm_sext8 : asm_val[31:0];

    field_asm u_asm (
        .clk     (clk),
        .rst     (rst),
        .clr     (asm_clr),
        .load    (asm_load),
        .byte_in (i_byte),
        .val     (asm_val),
        .sext8   (asm_sext8),
        .cnt     (asm_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_OPC;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        complete   = 1'b0;
        asm_load   = 1'b0;
        disp_latch = 1'b0;
        if (take) begin
            case (state)
                ST_OPC: begin
                    if (i_byte == OPC_NOP)          state_nxt = ST_OPC;
                    else if (has_modrm(i_byte))     state_nxt = ST_MODRM;
                    else if (imm_sz_cur != IMM_NONE) state_nxt = ST_IMM;
                    else                            state_nxt = ST_ILL;
                end
                ST_MODRM: begin
                    if (!modrm_ok)                    state_nxt = ST_ILL;
                    else if (disp_sz_cur != DISP_NONE) state_nxt = ST_DISP;
                    else if (imm_sz_cur != IMM_NONE)  state_nxt = ST_IMM;
                    else begin
                        complete  = 1'b1;
                        state_nxt = ST_OPC;
                    end
                end
                ST_DISP: begin
                    asm_load = 1'b1;
                    if (phase_last) begin
                        disp_latch = 1'b1;
                        if (imm_sz_cur != IMM_NONE) state_nxt = ST_IMM;
                        else begin
                            complete  = 1'b1;
                            state_nxt = ST_OPC;
                        end
                    end
                end
                ST_IMM: begin
                    asm_load = 1'b1;
                    if (phase_last) begin
                        complete  = 1'b1;
                        state_nxt = ST_OPC;
                    end
                end
                default: ;
            endcase
        end
        if (i_flush) begin
            state_nxt  = ST_OPC;
            complete   = 1'b0;
            asm_load   = 1'b0;
            disp_latch = 1'b0;
        end
        // The assembler restarts after every finished field, so the immediate
        // phase reuses it straight after the displacement.
        asm_clr = i_flush || (asm_load && phase_last);
    end

    always_comb begin
        d_sr1    = '0;
        d_sr2    = '0;
        d_addrbd = 1'b0;
        d_o1m    = 1'b0;
        d_o2m    = 1'b0;
        d_dsz    = DISP_NONE;
        d_disp   = '0;
        d_imm    = '0;
        if (is_add) begin
            d_sr1    = (opc_cur == OPC_ADD_R_RM) ? reg_f : rm_f;
            d_sr2    = (opc_cur == OPC_ADD_R_RM) ? rm_f : reg_f;
            d_addrbd = (mod_f == MOD_D8) || (mod_f == MOD_D32);
            d_o1m    = (opc_cur != OPC_ADD_R_RM) && (mod_f != MOD_REG);
            d_o2m    = (opc_cur == OPC_ADD_R_RM) && (mod_f != MOD_REG);
            d_dsz    = disp_sz_cur;
            if (disp_sz_cur != DISP_NONE) begin
                if (state == ST_DISP)     d_disp = disp_new;
                else if (state == ST_IMM) d_disp = disp_q;
            end
        end
        if (state == ST_IMM) begin
            case (imm_sz_cur)
                IMM_8:   d_imm = {16'h0, asm_sext8};
                IMM_32:  d_imm = {16'h0, asm_val[31:0]};
                IMM_48:  d_imm = asm_val;
                default: d_imm = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opc_q     <= '0;
            modrm_q   <= '0;
            len_q     <= '0;
            disp_q    <= '0;
            disp_sz_q <= DISP_NONE;
        end else if (i_flush) begin
            opc_q     <= '0;
            modrm_q   <= '0;
            len_q     <= '0;
            disp_q    <= '0;
            disp_sz_q <= DISP_NONE;
        end else begin
            if (take) begin
                if (state == ST_OPC) begin
                    opc_q <= i_byte;
                    len_q <= 4'd1;
                end else begin
                    len_q <= len_q + 4'd1;
                end
                if (state == ST_MODRM) begin
                    modrm_q   <= i_byte;
                    disp_sz_q <= disp_size_of(mod_f, rm_f);
                end
            end
            if (disp_latch) disp_q <= disp_new;
        end
    end

    // A completing byte can only be taken when the held output is free or
    // being consumed, so loading never overwrites a stalled instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || i_flush) begin
            o_vld       <= 1'b0;
            o_sr1       <= '0;
            o_sr2       <= '0;
            o_isAddrbd  <= 1'b0;
            o_isO1Mem   <= 1'b0;
            o_isO2Mem   <= 1'b0;
            o_far_jmp   <= 1'b0;
            o_immSize   <= IMM_NONE;
            o_imm       <= '0;
            o_disp      <= '0;
            o_disp_size <= DISP_NONE;
            o_op        <= OP_ADD;
            o_len       <= '0;
        end else if (complete) begin
            o_vld       <= 1'b1;
            o_sr1       <= d_sr1;
            o_sr2       <= d_sr2;
            o_isAddrbd  <= d_addrbd;
            o_isO1Mem   <= d_o1m;
            o_isO2Mem   <= d_o2m;
            o_far_jmp   <= (opc_cur == OPC_JMP_FAR);
            o_immSize   <= imm_sz_cur;
            o_imm       <= d_imm;
            o_disp      <= d_disp;
            o_disp_size <= d_dsz;
            o_op        <= op_of(opc_cur);
            o_len       <= len_q + 4'd1;
        end else if (!i_stall) begin
            o_vld <= 1'b0;
        end
    end
endmodule
